// File: rtl/iseq_loader_if.sv
// Signal bundle between the instruction-sequence loader, the host stream,
// the two instruction FIFOs and the dispatcher. master = loader side.
interface iseq_loader_if #(
    parameter int LEN_WIDTH = 16
);
    // app_en/app_ack: a word moves on every cycle where both are high; the host
    // holds app_instr stable until then and may not withdraw a word.
    logic                 app_en;
    logic [31:0]          app_instr;
    logic                 app_ack;
    logic                 instr0_fifo_wr;
    logic [31:0]          instr0_fifo_data;
    logic                 instr0_fifo_full;
    logic                 instr1_fifo_wr;
    logic [31:0]          instr1_fifo_data;
    logic                 instr1_fifo_full;
    logic                 process_iseq;
    logic                 dispatcher_busy;
    logic [LEN_WIDTH-1:0] iseq_len;
    logic                 iseq_done;

    modport master (
        input  app_en, app_instr, instr0_fifo_full, instr1_fifo_full, dispatcher_busy,
        output app_ack, instr0_fifo_wr, instr0_fifo_data, instr1_fifo_wr, instr1_fifo_data,
               process_iseq, iseq_len, iseq_done
    );

    modport slave (
        output app_en, app_instr, instr0_fifo_full, instr1_fifo_full, dispatcher_busy,
        input  app_ack, instr0_fifo_wr, instr0_fifo_data, instr1_fifo_wr, instr1_fifo_data,
               process_iseq, iseq_len, iseq_done
    );
endinterface

// File: rtl/iseq_loader.sv
// Splits a host instruction stream across two FIFOs (even/odd slots), pads odd
// sequences with a NOP, kicks the dispatcher and waits for it to finish.
module iseq_loader #(
    parameter int                     OPC_HI    = 31,
    parameter int                     OPC_LO    = 28,
    parameter logic [OPC_HI-OPC_LO:0] END_OPC   = '0,
    parameter logic [31:0]            NOP_INSTR = 32'h0,
    parameter int                     LEN_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    iseq_loader_if.master       bus,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_LOAD       = 3'd0,
        S_PAD        = 3'd1,
        S_KICK       = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4
    } state_e;

    state_e               state_q;
    logic                 slot_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 done_q;

    logic                 sel_full;
    logic                 ack;
    logic                 xfer;
    logic                 is_end;
    logic                 pad_wr;
    logic                 wr0;
    logic                 wr1;
    logic [LEN_WIDTH-1:0] len_d;

    // ack is gated by rst_n so the host sees no acceptance while reset is held.
    always_comb begin
        sel_full = slot_q ? bus.instr1_fifo_full : bus.instr0_fifo_full;
        ack      = rst_n && (state_q == S_LOAD) && !sel_full;
        xfer     = ack && bus.app_en;
        is_end   = (bus.app_instr[OPC_HI:OPC_LO] == END_OPC);
        pad_wr   = (state_q == S_PAD) && !bus.instr1_fifo_full;
        wr0      = xfer && !is_end && !slot_q;
        wr1      = (xfer && !is_end && slot_q) || pad_wr;
        len_d    = (len_q == '1) ? len_q : len_q + LEN_WIDTH'(1);
    end

    assign bus.app_ack          = ack;
    assign bus.instr0_fifo_wr   = wr0;
    assign bus.instr0_fifo_data = wr0 ? bus.app_instr : 32'h0;
    assign bus.instr1_fifo_wr   = wr1;
    assign bus.instr1_fifo_data = pad_wr ? NOP_INSTR : (wr1 ? bus.app_instr : 32'h0);
    assign bus.process_iseq     = (state_q == S_KICK);
    assign bus.iseq_len         = len_q;
    assign bus.iseq_done        = done_q;
    assign dbg_state_o          = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            slot_q  <= 1'b0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        if (!is_end) begin
                            slot_q <= ~slot_q;
                            len_q  <= len_d;
                        end else if (len_q == '0) begin
                            // Empty sequence: nothing to dispatch, retire at once.
                            done_q <= 1'b1;
                        end else if (slot_q) begin
                            state_q <= S_PAD;
                        end else begin
                            state_q <= S_KICK;
                        end
                    end
                end
                S_PAD: begin
                    if (!bus.instr1_fifo_full) begin
                        slot_q  <= 1'b0;
                        state_q <= S_KICK;
                    end
                end
                S_KICK: begin
                    state_q <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (bus.dispatcher_busy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.dispatcher_busy) begin
                        done_q  <= 1'b1;
                        len_q   <= '0;
                        slot_q  <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iseq_loader.sv
// Bench for iseq_loader: host driver, dispatcher model and a per-FIFO scoreboard
// of expected write words, with one task per scenario.
module tb_iseq_loader;
    localparam int          TB_LEN_W = 4;
    localparam logic [31:0] NOP      = 32'h0;
    localparam logic [2:0]  ST_LOAD  = 3'd0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    iseq_loader_if #(.LEN_WIDTH(TB_LEN_W)) bus ();

    iseq_loader #(.LEN_WIDTH(TB_LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset / counters ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int kick_cnt = 0, done_cnt = 0;
    int last_kick_cyc = -1, last_done_cyc = -1, last_wr1_cyc = -1;
    logic model_slot = 1'b0;
    int   model_len = 0;

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.process_iseq === 1'b1) begin kick_cnt++; last_kick_cyc = cyc; end
        if (bus.iseq_done === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
        if (bus.instr0_fifo_wr === 1'b1) begin
            n_checks++;
            if (exp0_q.size() == 0)
                $display("FAIL wr0_unexpected: got write %h, required no write", bus.instr0_fifo_data);
            else begin
                e = exp0_q.pop_front();
                if (bus.instr0_fifo_data !== e) $display("FAIL wr0_data: got %h, required %h", bus.instr0_fifo_data, e);
                else n_pass++;
            end
            n_checks++;
            if (bus.instr0_fifo_full !== 1'b0) $display("FAIL wr0_while_full: got full=%b, required 0", bus.instr0_fifo_full);
            else n_pass++;
        end
        if (bus.instr1_fifo_wr === 1'b1) begin
            last_wr1_cyc = cyc;
            n_checks++;
            if (exp1_q.size() == 0)
                $display("FAIL wr1_unexpected: got write %h, required no write", bus.instr1_fifo_data);
            else begin
                e = exp1_q.pop_front();
                if (bus.instr1_fifo_data !== e) $display("FAIL wr1_data: got %h, required %h", bus.instr1_fifo_data, e);
                else n_pass++;
            end
            n_checks++;
            if (bus.instr1_fifo_full !== 1'b0) $display("FAIL wr1_while_full: got full=%b, required 0", bus.instr1_fifo_full);
            else n_pass++;
            n_checks++;
            if (bus.instr0_fifo_wr !== 1'b0) $display("FAIL dual_write: got wr0=%b with wr1, required 0", bus.instr0_fifo_wr);
            else n_pass++;
        end
        if (bus.instr0_fifo_wr === 1'b0) begin
            n_checks++;
            if (bus.instr0_fifo_data !== 32'h0) $display("FAIL data0_idle: got %h, required 0", bus.instr0_fifo_data);
            else n_pass++;
        end
        if (bus.instr1_fifo_wr === 1'b0) begin
            n_checks++;
            if (bus.instr1_fifo_data !== 32'h0) $display("FAIL data1_idle: got %h, required 0", bus.instr1_fifo_data);
            else n_pass++;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        w[31:28] = 4'($urandom_range(1, 15));
        return w;
    endfunction

    function automatic logic [31:0] end_word();
        logic [31:0] w;
        w = $urandom;
        w[31:28] = 4'h0;
        return w;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; ack_cyc is the cycle of the transfer.
    task automatic send_word(input logic [31:0] w, output int ack_cyc);
        bit got = 0;
        ack_cyc = -1;
        bus.app_en = 1'b1;
        bus.app_instr = w;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.app_ack === 1'b1) begin got = 1; ack_cyc = cyc; end
        end
        @(posedge clk); #1;
        bus.app_en = 1'b0;
        bus.app_instr = 32'h0;
        n_checks++;
        if (!got) $display("FAIL send_timeout: no ack for %h, required ack within 100 cycles", w);
        else n_pass++;
    endtask

    task automatic host_data(input logic [31:0] w, output int ack_cyc);
        if (model_slot) exp1_q.push_back(w);
        else exp0_q.push_back(w);
        model_slot = ~model_slot;
        if (model_len < 15) model_len++;
        send_word(w, ack_cyc);
    endtask

    task automatic host_end(output int ack_cyc);
        if (model_slot) exp1_q.push_back(NOP);
        send_word(end_word(), ack_cyc);
    endtask

    task automatic model_clear();
        model_slot = 1'b0;
        model_len = 0;
    endtask

    // Dispatcher model: busy rises the cycle after the kick, stays for busy_cycles.
    task automatic run_dispatcher(input int busy_cycles, output int kick_cyc, output int fall_cyc);
        bit got = 0;
        kick_cyc = -1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.process_iseq === 1'b1) begin got = 1; kick_cyc = cyc; end
        end
        n_checks++;
        if (!got) $display("FAIL kick_timeout: process_iseq=0, required a pulse within 20 cycles");
        else n_pass++;
        @(posedge clk); #1;
        bus.dispatcher_busy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.app_ack !== 1'b0) $display("FAIL busy_ack: got app_ack=%b, required 0", bus.app_ack);
            else n_pass++;
            @(posedge clk);
        end
        #1;
        bus.dispatcher_busy = 1'b0;
        fall_cyc = cyc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.app_en = 1'b1;
        bus.app_instr = rand_word();
        @(negedge clk);
        n_checks++; if (bus.app_ack !== 1'b0) $display("FAIL rst_ack: got %b, required 0", bus.app_ack); else n_pass++;
        n_checks++; if (bus.instr0_fifo_wr !== 1'b0) $display("FAIL rst_wr0: got %b, required 0", bus.instr0_fifo_wr); else n_pass++;
        n_checks++; if (bus.instr1_fifo_wr !== 1'b0) $display("FAIL rst_wr1: got %b, required 0", bus.instr1_fifo_wr); else n_pass++;
        n_checks++; if (bus.process_iseq !== 1'b0) $display("FAIL rst_kick: got %b, required 0", bus.process_iseq); else n_pass++;
        n_checks++; if (bus.iseq_done !== 1'b0) $display("FAIL rst_done: got %b, required 0", bus.iseq_done); else n_pass++;
        n_checks++; if (bus.iseq_len !== '0) $display("FAIL rst_len: got %0d, required 0", bus.iseq_len); else n_pass++;
        n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL rst_state: got %0d, required %0d", dbg_state, ST_LOAD); else n_pass++;
        @(posedge clk); #1;
        bus.app_en = 1'b0;
        bus.app_instr = 32'h0;
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_even_seq();
        int c, end_c, k, f, kc0, dc0;
        kc0 = kick_cnt; dc0 = done_cnt;
        for (int i = 0; i < 4; i++) host_data(rand_word(), c);
        host_end(end_c);
        n_checks++; if (bus.iseq_len !== 4'd4) $display("FAIL even_len: got %0d, required 4", bus.iseq_len); else n_pass++;
        run_dispatcher(2, k, f);
        n_checks++; if (k !== end_c + 1) $display("FAIL even_kick_cyc: got %0d, required %0d", k, end_c + 1); else n_pass++;
        wait_cycles(2);
        model_clear();
        n_checks++; if (kick_cnt - kc0 !== 1) $display("FAIL even_kick_cnt: got %0d, required 1", kick_cnt - kc0); else n_pass++;
        n_checks++; if (done_cnt - dc0 !== 1) $display("FAIL even_done_cnt: got %0d, required 1", done_cnt - dc0); else n_pass++;
        n_checks++; if (last_done_cyc !== f + 1) $display("FAIL even_done_cyc: got %0d, required %0d", last_done_cyc, f + 1); else n_pass++;
        n_checks++; if (bus.iseq_len !== '0) $display("FAIL even_len_clr: got %0d, required 0", bus.iseq_len); else n_pass++;
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL even_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    task automatic test_odd_pad();
        int c, end_c, k, f;
        for (int i = 0; i < 3; i++) host_data(rand_word(), c);
        host_end(end_c);
        n_checks++; if (bus.iseq_len !== 4'd3) $display("FAIL odd_len: got %0d, required 3", bus.iseq_len); else n_pass++;
        run_dispatcher(2, k, f);
        n_checks++; if (last_wr1_cyc !== end_c + 1) $display("FAIL pad_cyc: got %0d, required %0d", last_wr1_cyc, end_c + 1); else n_pass++;
        n_checks++; if (k !== last_wr1_cyc + 1) $display("FAIL pad_kick_cyc: got %0d, required %0d", k, last_wr1_cyc + 1); else n_pass++;
        wait_cycles(2);
        model_clear();
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL odd_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    task automatic test_full_stall();
        int c, s, end_c, k, f;
        logic [31:0] w1;
        bus.instr1_fifo_full = 1'b1;
        s = cyc;
        host_data(rand_word(), c);
        n_checks++; if (c !== s) $display("FAIL other_full_stall: ack cycle %0d, required %0d", c, s); else n_pass++;
        w1 = rand_word();
        exp1_q.push_back(w1);
        model_slot = 1'b0;
        model_len++;
        bus.app_en = 1'b1;
        bus.app_instr = w1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.app_ack !== 1'b0) $display("FAIL stall_ack: got %b, required 0", bus.app_ack); else n_pass++;
            n_checks++; if (bus.instr1_fifo_wr !== 1'b0) $display("FAIL stall_wr1: got %b, required 0", bus.instr1_fifo_wr); else n_pass++;
            @(posedge clk);
        end
        #1;
        bus.instr1_fifo_full = 1'b0;
        bus.instr0_fifo_full = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.app_ack !== 1'b1) $display("FAIL unstall_ack: got %b, required 1", bus.app_ack); else n_pass++;
        n_checks++; if (bus.instr1_fifo_wr !== 1'b1) $display("FAIL unstall_wr1: got %b, required 1", bus.instr1_fifo_wr); else n_pass++;
        @(posedge clk); #1;
        bus.app_en = 1'b0;
        bus.app_instr = 32'h0;
        bus.instr0_fifo_full = 1'b0;
        host_end(end_c);
        run_dispatcher(1, k, f);
        n_checks++; if (k !== end_c + 1) $display("FAIL stall_kick_cyc: got %0d, required %0d", k, end_c + 1); else n_pass++;
        wait_cycles(2);
        model_clear();
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL stall_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    task automatic test_end_first();
        int c, kc0, dc0;
        kc0 = kick_cnt; dc0 = done_cnt;
        host_end(c);
        wait_cycles(2);
        n_checks++; if (done_cnt - dc0 !== 1) $display("FAIL empty_done_cnt: got %0d, required 1", done_cnt - dc0); else n_pass++;
        n_checks++; if (last_done_cyc !== c + 1) $display("FAIL empty_done_cyc: got %0d, required %0d", last_done_cyc, c + 1); else n_pass++;
        n_checks++; if (kick_cnt - kc0 !== 0) $display("FAIL empty_kick: got %0d pulses, required 0", kick_cnt - kc0); else n_pass++;
        n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL empty_state: got %0d, required %0d", dbg_state, ST_LOAD); else n_pass++;
    endtask

    task automatic test_long_busy();
        int c, end_c, k, f, kc0, dc0;
        logic [31:0] w;
        kc0 = kick_cnt; dc0 = done_cnt;
        host_data(rand_word(), c);
        host_data(rand_word(), c);
        host_end(end_c);
        model_clear();
        w = rand_word();
        bus.app_en = 1'b1;
        bus.app_instr = w;
        run_dispatcher(10, k, f);
        exp0_q.push_back(w);
        model_slot = 1'b1;
        model_len = 1;
        send_word(w, c);
        n_checks++; if (c !== f + 1) $display("FAIL busy_next_ack: got cycle %0d, required %0d", c, f + 1); else n_pass++;
        n_checks++; if (last_done_cyc !== f + 1) $display("FAIL busy_done_cyc: got %0d, required %0d", last_done_cyc, f + 1); else n_pass++;
        host_end(end_c);
        run_dispatcher(3, k, f);
        wait_cycles(2);
        model_clear();
        n_checks++; if (kick_cnt - kc0 !== 2) $display("FAIL busy_kick_cnt: got %0d, required 2", kick_cnt - kc0); else n_pass++;
        n_checks++; if (done_cnt - dc0 !== 2) $display("FAIL busy_done_cnt: got %0d, required 2", done_cnt - dc0); else n_pass++;
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL busy_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    task automatic test_reset_wait_done();
        int c, end_c, k, f;
        bit got = 0;
        host_data(rand_word(), c);
        host_data(rand_word(), c);
        host_end(end_c);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.process_iseq === 1'b1) got = 1;
        end
        @(posedge clk); #1;
        bus.dispatcher_busy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (dbg_state !== 3'd4) $display("FAIL pre_rst_state: got %0d, required 4", dbg_state); else n_pass++;
        bus.app_en = 1'b1;
        bus.app_instr = rand_word();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.app_ack !== 1'b0) $display("FAIL arst_ack: got %b, required 0", bus.app_ack); else n_pass++;
        n_checks++; if (bus.instr0_fifo_wr !== 1'b0) $display("FAIL arst_wr0: got %b, required 0", bus.instr0_fifo_wr); else n_pass++;
        n_checks++; if (bus.process_iseq !== 1'b0) $display("FAIL arst_kick: got %b, required 0", bus.process_iseq); else n_pass++;
        n_checks++; if (bus.iseq_done !== 1'b0) $display("FAIL arst_done: got %b, required 0", bus.iseq_done); else n_pass++;
        n_checks++; if (bus.iseq_len !== '0) $display("FAIL arst_len: got %0d, required 0", bus.iseq_len); else n_pass++;
        n_checks++; if (dbg_state !== ST_LOAD) $display("FAIL arst_state: got %0d, required %0d", dbg_state, ST_LOAD); else n_pass++;
        bus.app_en = 1'b0;
        bus.app_instr = 32'h0;
        bus.dispatcher_busy = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_clear();
        host_data(rand_word(), c);
        host_data(rand_word(), c);
        host_data(rand_word(), c);
        host_end(end_c);
        run_dispatcher(2, k, f);
        wait_cycles(2);
        model_clear();
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL arst_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    task automatic test_saturation();
        int c, end_c, k, f;
        for (int i = 0; i < 15; i++) host_data(rand_word(), c);
        n_checks++; if (bus.iseq_len !== 4'd15) $display("FAIL sat_len15: got %0d, required 15", bus.iseq_len); else n_pass++;
        for (int i = 0; i < 3; i++) host_data(rand_word(), c);
        n_checks++; if (bus.iseq_len !== 4'(model_len)) $display("FAIL sat_len: got %0d, required %0d", bus.iseq_len, model_len); else n_pass++;
        host_end(end_c);
        run_dispatcher(2, k, f);
        n_checks++; if (k !== end_c + 1) $display("FAIL sat_kick_cyc: got %0d, required %0d", k, end_c + 1); else n_pass++;
        wait_cycles(2);
        model_clear();
        n_checks++; if (exp0_q.size() + exp1_q.size() !== 0) $display("FAIL sat_drain: got %0d pending, required 0", exp0_q.size() + exp1_q.size()); else n_pass++;
    endtask

    initial begin
        bus.app_en = 1'b0;
        bus.app_instr = 32'h0;
        bus.instr0_fifo_full = 1'b0;
        bus.instr1_fifo_full = 1'b0;
        bus.dispatcher_busy = 1'b0;
        test_reset();
        test_even_seq();
        test_odd_pad();
        test_full_stall();
        test_end_first();
        test_long_busy();
        test_reset_wait_done();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at 400us, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
